// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture controller: PDM clock divider, CIC filter reset and settle sequencing,
// and a show-ahead PCM sample FIFO with overflow and watermark interrupt.
module pdm_capture_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_en,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [7:0]                  cfg_settle,
  input  logic [3:0]                  cfg_wm,
  output logic                        pdm_clk_o,
  output logic                        filt_rst,
  input  logic [15:0]                 pcm_in,
  input  logic                        pcm_valid_in,
  input  logic                        rd_en,
  output logic [15:0]                 rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        ovf,
  input  logic                        ovf_clr,
  input  logic                        flush,
  output logic                        irq,
  output logic [1:0]                  state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [4:0]    DEPTH_5 = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0] r_discard;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    filt_rst     = 1'b0;
    case (r_state)
      IDLE: begin
        filt_rst = 1'b1;
        if (cfg_en) w_state_next = SETTLE;
      end
      SETTLE: begin
        if (r_discard >= cfg_settle) w_state_next = RUN;
      end
      RUN: begin
        w_state_next = RUN;
      end
      default: begin
        filt_rst     = 1'b1;
        w_state_next = IDLE;
      end
    endcase
    if (!cfg_en) w_state_next = IDLE;
  end

  assign state_o = r_state;

  // ---------------------------------------------------------------- PDM clock divider
  logic [DIV_W-1:0] r_phase;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_cfg;
  logic [DIV_W-1:0] w_div_cur;
  logic             r_pdm_clk;

  assign w_div_cfg = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  // A new period length is only picked up at phase 0, so a cfg_div change lands on a wrap.
  assign w_div_cur = (r_phase == '0) ? w_div_cfg : r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= '0;
      r_div     <= DIV_W'(2);
      r_pdm_clk <= 1'b0;
    end else if (w_state_next == IDLE) begin
      r_phase   <= '0;
      r_div     <= w_div_cfg;
      r_pdm_clk <= 1'b0;
    end else begin
      r_pdm_clk <= (r_phase < (w_div_cur >> 1));
      r_div     <= w_div_cur;
      if (r_phase >= (w_div_cur - DIV_W'(1))) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + DIV_W'(1);
      end
    end
  end

  assign pdm_clk_o = r_pdm_clk;

  // ---------------------------------------------------------------- valid synchroniser
  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic w_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= pcm_valid_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Acted upon at the third edge after the raw rise; pcm_in is still stable there.
  assign w_evt = r_sync2 & ~r_sync3;

  // ---------------------------------------------------------------- settle discard counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard <= '0;
    end else if (r_state == IDLE) begin
      r_discard <= '0;
    end else if ((r_state == SETTLE) && w_evt && (r_discard != 8'hFF)) begin
      r_discard <= r_discard + 8'd1;
    end
  end

  // ---------------------------------------------------------------- sample FIFO
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_irq;

  logic w_push_req;
  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;
  logic w_ovf_set;

  assign w_push_req = w_evt && (r_state == RUN);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_do_pop   = rd_en && !w_empty && !flush;
  // When full, a same-cycle pop frees the slot the push needs.
  assign w_do_push  = w_push_req && (!w_full || w_do_pop) && !flush;
  assign w_ovf_set  = w_push_req && w_full && !w_do_pop && !flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= pcm_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- interrupt
  logic [4:0] w_wm_raw;
  logic [4:0] w_wm_eff;
  logic [4:0] w_count_5;
  logic       w_wm_hit;

  assign w_wm_raw  = {1'b0, cfg_wm};
  assign w_wm_eff  = (w_wm_raw > DEPTH_5) ? DEPTH_5 : w_wm_raw;
  assign w_count_5 = 5'(r_count);
  assign w_wm_hit  = (cfg_wm != 4'd0) && (w_count_5 >= w_wm_eff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_wm_hit || r_ovf;
    end
  end

  assign rd_data    = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign ovf        = r_ovf;
  assign irq        = r_irq;

endmodule
